control_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute FSM that drives the register file's strobes:

---
 rtl/control_sequencer_pkg.sv | 65 ++++++
 rtl/control_sequencer_mem_wait_timer.sv | 32 +++
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer:
// opcodes, FSM states, register/bus indices, ALU ops.
package control_sequencer_pkg;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_LDAC  = 6'd1;
  localparam logic [5:0] OP_STAC  = 6'd2;
  localparam logic [5:0] OP_MVACR = 6'd3;
  localparam logic [5:0] OP_ADD   = 6'd4;
  localparam logic [5:0] OP_SUB   = 6'd5;
  localparam logic [5:0] OP_INAC  = 6'd6;
  localparam logic [5:0] OP_JUMP  = 6'd7;
  localparam logic [5:0] OP_JMPZ  = 6'd8;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [3:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_EXEC0,
    S_EXEC1,
    S_EXEC2,
    S_MEMRD,
    S_MEMWR,
    S_HALT
  } state_t;

  localparam logic [2:0] REG_AR = 3'd0;
  localparam logic [2:0] REG_PC = 3'd1;
  localparam logic [2:0] REG_AC = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;

  // C-bus sources: register indices first, then DR and ALU result
  localparam logic [2:0] BUS_AR  = 3'd0;
  localparam logic [2:0] BUS_PC  = 3'd1;
  localparam logic [2:0] BUS_AC  = 3'd2;
  localparam logic [2:0] BUS_R3  = 3'd3;
  localparam logic [2:0] BUS_DR  = 3'd4;
  localparam logic [2:0] BUS_ALU = 3'd5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef struct packed {
    logic       ldir;
    logic       dr_read;
    logic       dr_we;
    logic       wr;
    logic [2:0] widx;
    logic       pc_inc;
    logic       ac_inc;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts consecutive RAM wait cycles; flags the
// last allowed one. MEM_TO = 0 never expires.
module mem_wait_timer #(
  parameter int MEM_TO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((MEM_TO > 0) ? MEM_TO - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (MEM_TO != 0) && enable &&
                   (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer; emits one
// registered control word per clock.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int NREG   = 8,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  ir_opcode,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            ldir,
  output logic            dr_read,
  output logic            dr_we,
  output logic [NREG-1:0] reg_we,
  output logic            pc_inc,
  output logic            ac_inc,
  output logic [2:0]      bus_sel,
  output logic [2:0]      alu_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            halted,
  output logic            fault
);

  state_t     state;
  state_t     nxt;
  logic       primed;
  ctrl_t      cw;
  ctrl_t      cw_q;
  logic       waiting;
  logic       tmr_en;
  logic       tmr_exp;
  logic [5:0] op;

  assign op      = 6'(ir_opcode);
  assign waiting = (state == S_FETCH1) ||
                   (state == S_MEMRD) ||
                   (state == S_MEMWR);
  assign tmr_en  = waiting && !mem_ready;

  mem_wait_timer #(
    .MEM_TO (MEM_TO)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!tmr_en),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH0;
      primed <= 1'b0;
      cw_q   <= '0;
    end else begin
      state  <= nxt;
      primed <= 1'b1;
      cw_q   <= cw;
    end
  end

  // First edge after reset re-enters FETCH0 so its
  // strobes (held at 0 during reset) are issued.
  always_comb begin
    nxt = state;
    if (!primed) begin
      nxt = S_FETCH0;
    end else begin
      unique case (state)
        S_FETCH0: nxt = S_FETCH1;
        S_FETCH1: begin
          if (mem_ready)    nxt = S_FETCH2;
          else if (tmr_exp) nxt = S_HALT;
        end
        S_FETCH2: nxt = S_FETCH3;
        S_FETCH3: nxt = S_DECODE;
        S_DECODE: begin
          nxt = (op == OP_HALT) ? S_HALT : S_EXEC0;
        end
        S_EXEC0: begin
          case (op)
            OP_LDAC: nxt = S_MEMRD;
            OP_STAC: nxt = S_MEMWR;
            OP_JMPZ: nxt = z_flag ? S_EXEC1 : S_FETCH0;
            default: nxt = S_FETCH0;
          endcase
        end
        S_MEMRD: begin
          if (mem_ready)    nxt = S_EXEC1;
          else if (tmr_exp) nxt = S_HALT;
        end
        S_MEMWR: begin
          if (mem_ready)    nxt = S_FETCH0;
          else if (tmr_exp) nxt = S_HALT;
        end
        S_EXEC1: begin
          nxt = (op == OP_LDAC) ? S_EXEC2 : S_FETCH0;
        end
        S_EXEC2: nxt = S_FETCH0;
        S_HALT:  nxt = S_HALT;
        default: nxt = S_FETCH0;
      endcase
    end
  end

  always_comb begin
    cw       = '0;
    cw.fault = cw_q.fault | tmr_exp;
    unique case (nxt)
      S_FETCH0: begin
        cw.wr      = 1'b1;
        cw.widx    = REG_AR;
        cw.bus_sel = BUS_PC;
      end
      S_FETCH1: cw.mem_rd = 1'b1;
      S_FETCH2: begin
        cw.dr_read = 1'b1;
        cw.dr_we   = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      S_FETCH3: cw.ldir = 1'b1;
      S_DECODE: cw.ldir = 1'b0;
      S_EXEC0: begin
        case (op)
          OP_LDAC: begin
            cw.wr      = 1'b1;
            cw.widx    = REG_AR;
            cw.bus_sel = BUS_PC;
          end
          OP_STAC: begin
            cw.dr_we   = 1'b1;
            cw.bus_sel = BUS_AC;
          end
          OP_MVACR: begin
            cw.wr      = 1'b1;
            cw.widx    = REG_R3;
            cw.bus_sel = BUS_AC;
          end
          OP_ADD, OP_SUB: begin
            cw.wr      = 1'b1;
            cw.widx    = REG_AC;
            cw.bus_sel = BUS_ALU;
            cw.alu_op  = (op == OP_ADD) ? ALU_ADD
                                        : ALU_SUB;
          end
          OP_INAC: cw.ac_inc = 1'b1;
          OP_JUMP: begin
            cw.wr      = 1'b1;
            cw.widx    = REG_PC;
            cw.bus_sel = BUS_DR;
          end
          default: cw.alu_op = ALU_PASS;
        endcase
      end
      S_MEMRD: cw.mem_rd = 1'b1;
      S_MEMWR: cw.mem_wr = 1'b1;
      S_EXEC1: begin
        if (op == OP_LDAC) begin
          cw.dr_read = 1'b1;
          cw.dr_we   = 1'b1;
          cw.pc_inc  = 1'b1;
        end else begin
          cw.wr      = 1'b1;
          cw.widx    = REG_PC;
          cw.bus_sel = BUS_DR;
        end
      end
      S_EXEC2: begin
        cw.wr      = 1'b1;
        cw.widx    = REG_AC;
        cw.bus_sel = BUS_DR;
      end
      S_HALT:  cw.halted = 1'b1;
      default: cw.halted = 1'b0;
    endcase
  end

  assign ldir    = cw_q.ldir;
  assign dr_read = cw_q.dr_read;
  assign dr_we   = cw_q.dr_we;
  assign reg_we  = cw_q.wr ? (NREG'(1) << cw_q.widx)
                           : '0;
  assign pc_inc  = cw_q.pc_inc;
  assign ac_inc  = cw_q.ac_inc;
  assign bus_sel = cw_q.bus_sel;
  assign alu_op  = cw_q.alu_op;
  assign mem_rd  = cw_q.mem_rd;
  assign mem_wr  = cw_q.mem_wr;
  assign halted  = cw_q.halted;
  assign fault   = cw_q.fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: expected control words queued per
// cycle and compared one cycle later.
module tb_control_sequencer;

  typedef struct packed {
    logic       ldir;
    logic       dr_read;
    logic       dr_we;
    logic [7:0] reg_we;
    logic       pc_inc;
    logic       ac_inc;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       fault;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] ir_opcode;
  logic       z_flag;
  logic       mem_ready;
  logic       ldir;
  logic       dr_read;
  logic       dr_we;
  logic [7:0] reg_we;
  logic       pc_inc;
  logic       ac_inc;
  logic [2:0] bus_sel;
  logic [2:0] alu_op;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
  logic       fault;

  exp_t obs;
  exp_t sb[$];
  int   tests;
  int   fails;

  control_sequencer #(
    .OPW    (6),
    .NREG   (8),
    .MEM_TO (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_opcode (ir_opcode),
    .z_flag    (z_flag),
    .mem_ready (mem_ready),
    .ldir      (ldir),
    .dr_read   (dr_read),
    .dr_we     (dr_we),
    .reg_we    (reg_we),
    .pc_inc    (pc_inc),
    .ac_inc    (ac_inc),
    .bus_sel   (bus_sel),
    .alu_op    (alu_op),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted),
    .fault     (fault)
  );

  assign obs = {ldir, dr_read, dr_we, reg_we,
                pc_inc, ac_inc, bus_sel, alu_op,
                mem_rd, mem_wr, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t f_zero();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t f_wr(input int idx,
                                input logic [2:0] bus,
                                input logic [2:0] alu);
    exp_t e = '0;
    e.reg_we  = 8'b1 << idx;
    e.bus_sel = bus;
    e.alu_op  = alu;
    return e;
  endfunction

  function automatic exp_t f_f0();
    return f_wr(0, 3'd1, 3'd0);
  endfunction

  function automatic exp_t f_mr();
    exp_t e = '0;
    e.mem_rd = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_mw();
    exp_t e = '0;
    e.mem_wr = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_dr_ram();
    exp_t e = '0;
    e.dr_read = 1'b1;
    e.dr_we   = 1'b1;
    e.pc_inc  = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_ldir();
    exp_t e = '0;
    e.ldir = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_halt(input logic flt);
    exp_t e = '0;
    e.halted = 1'b1;
    e.fault  = flt;
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t x;
    x = sb.pop_front();
    tests++;
    assert (obs === x) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, x);
    end
  endtask

  task automatic chk_now(input exp_t e,
                         input string tag);
    sb.push_back(e);
    check(tag);
  endtask

  task automatic cyc(input exp_t e, input logic rdy,
                     input string tag);
    mem_ready = rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // From FETCH0 through DECODE; waits = extra
  // not-ready FETCH1 cycles before mem_ready.
  task automatic fetch(input logic [5:0] op,
                       input int waits);
    cyc(f_mr(), 1'b0, "fetch1");
    for (int i = 0; i < waits; i++)
      cyc(f_mr(), 1'b0, "fetch1_wait");
    cyc(f_dr_ram(), 1'b1, "fetch2");
    cyc(f_ldir(), 1'b0, "fetch3");
    ir_opcode = op;
    cyc(f_zero(), 1'b0, "decode");
  endtask

  initial begin
    exp_t e;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    ir_opcode = 6'd0;
    z_flag    = 1'b0;
    mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_now(f_zero(), "reset_hold");
    rst_n = 1'b1;
    cyc(f_f0(), 1'b0, "release_fetch0");

    cyc(f_mr(), 1'b0, "pre_reset_fetch1");
    #3;
    rst_n = 1'b0;
    #1;
    chk_now(f_zero(), "reset_mid_fetch1");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(f_f0(), 1'b0, "release2_fetch0");

    fetch(6'd4, 3);
    cyc(f_wr(2, 3'd5, 3'd1), 1'b0, "add_exec0");
    cyc(f_f0(), 1'b0, "add_done");

    fetch(6'd5, 0);
    cyc(f_wr(2, 3'd5, 3'd2), 1'b0, "sub_exec0");
    cyc(f_f0(), 1'b0, "sub_done");

    fetch(6'd3, 0);
    cyc(f_wr(3, 3'd2, 3'd0), 1'b0, "mvacr_exec0");
    cyc(f_f0(), 1'b0, "mvacr_done");

    fetch(6'd6, 0);
    e = '0;
    e.ac_inc = 1'b1;
    cyc(e, 1'b0, "inac_exec0");
    cyc(f_f0(), 1'b0, "inac_done");

    fetch(6'd7, 0);
    cyc(f_wr(1, 3'd4, 3'd0), 1'b0, "jump_exec0");
    cyc(f_f0(), 1'b0, "jump_done");

    fetch(6'd8, 0);
    z_flag = 1'b1;
    cyc(f_zero(), 1'b0, "jmpz0_exec0");
    z_flag = 1'b0;
    cyc(f_f0(), 1'b0, "jmpz0_not_taken");

    fetch(6'd8, 1);
    z_flag = 1'b0;
    cyc(f_zero(), 1'b0, "jmpz1_exec0");
    z_flag = 1'b1;
    cyc(f_wr(1, 3'd4, 3'd0), 1'b0, "jmpz1_taken");
    z_flag = 1'b0;
    cyc(f_f0(), 1'b0, "jmpz1_done");

    fetch(6'd1, 0);
    cyc(f_wr(0, 3'd1, 3'd0), 1'b0, "ldac_ar");
    cyc(f_mr(), 1'b0, "ldac_memrd");
    cyc(f_mr(), 1'b0, "ldac_wait");
    cyc(f_dr_ram(), 1'b1, "ldac_dr");
    cyc(f_wr(2, 3'd4, 3'd0), 1'b0, "ldac_ac");
    cyc(f_f0(), 1'b0, "ldac_done");

    fetch(6'd2, 0);
    e = '0;
    e.dr_we   = 1'b1;
    e.bus_sel = 3'd2;
    cyc(e, 1'b0, "stac_dr");
    cyc(f_mw(), 1'b0, "stac_memwr");
    cyc(f_mw(), 1'b0, "stac_wait");
    cyc(f_f0(), 1'b1, "stac_done");

    fetch(6'd42, 0);
    cyc(f_zero(), 1'b1, "op42_exec0");
    cyc(f_f0(), 1'b1, "op42_done");

    cyc(f_mr(), 1'b0, "to_fetch1");
    for (int i = 0; i < 14; i++)
      cyc(f_mr(), 1'b0, "to_wait");
    cyc(f_halt(1'b1), 1'b0, "to_fault");
    for (int i = 0; i < 20; i++)
      cyc(f_halt(1'b1), 1'($urandom_range(0, 1)),
          "to_stuck");

    rst_n = 1'b0;
    #1;
    chk_now(f_zero(), "to_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(f_f0(), 1'b0, "release3_fetch0");

    fetch(6'd63, 0);
    cyc(f_halt(1'b0), 1'b0, "halt_entry");
    for (int i = 0; i < 100; i++) begin
      ir_opcode = 6'($urandom_range(0, 63));
      z_flag    = 1'($urandom_range(0, 1));
      cyc(f_halt(1'b0), 1'($urandom_range(0, 1)),
          "halt_stuck");
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
